// File: rtl/digital_pll_pkg.sv
// Shared definitions for the digital PLL: FLL controller state, code-width helper
// and default parameter values.
package digital_pll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DCO   = 2'd2
  } fll_state_e;

  localparam int TRIM_W_DEF      = 26;
  localparam int DIV_W_DEF       = 5;
  localparam int TRIM_INIT_DEF   = 13;
  localparam int TOL_DEF         = 1;
  localparam int COARSE_TH_DEF   = 4;
  localparam int COARSE_STEP_DEF = 4;
  localparam int LOCK_COUNT_DEF  = 8;

  // Code spans 0..trim_w inclusive.
  function automatic int code_w(input int trim_w);
    return $clog2(trim_w + 1);
  endfunction

endpackage

// File: rtl/fll_osc_edge.sv
// Brings the asynchronous reference clock into the DCO domain and flags its
// rising edges with a one-cycle pulse.
module fll_osc_edge (
  input  logic clock,
  input  logic reset,
  input  logic osc,
  output logic osc_rise
);

  // [0],[1] synchroniser, [2] delayed copy for edge detection
  logic [2:0] sync;

  always_ff @(posedge clock) begin
    if (reset) sync <= '0;
    else       sync <= {sync[1:0], osc};
  end

  assign osc_rise = sync[1] & ~sync[2];

endmodule

// File: rtl/digital_fll_controller.sv
// FLL controller: measures DCO cycles per reference period and steps a saturating
// thermometer trim code. Optional lock detector enabled by FLL_LOCK_DETECT_EN.
module digital_fll_controller
  import digital_pll_pkg::*;
#(
  parameter  int TRIM_W      = TRIM_W_DEF,
  parameter  int DIV_W       = DIV_W_DEF,
  parameter  int TRIM_INIT   = TRIM_INIT_DEF,
  parameter  int TOL         = TOL_DEF,
  parameter  int COARSE_TH   = COARSE_TH_DEF,
  parameter  int COARSE_STEP = COARSE_STEP_DEF,
  parameter  int LOCK_COUNT  = LOCK_COUNT_DEF,
  localparam int CODE_W      = code_w(TRIM_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              osc,
  input  logic [DIV_W-1:0]  div,
  input  logic              dco,
  input  logic [TRIM_W-1:0] ext_trim,
  output logic [TRIM_W-1:0] trim,
  output logic [CODE_W-1:0] code,
  output logic              locked
);

  localparam int CNT_W = DIV_W + 2;
  localparam int ERR_W = DIV_W + 3;

  fll_state_e              state, state_n;
  logic                    osc_rise, eval, in_win;
  logic [CNT_W-1:0]        cnt;
  logic signed [ERR_W-1:0] err;
  logic [ERR_W-1:0]        err_abs;
  logic [CODE_W:0]         code_x, step, sum;
  logic [CODE_W-1:0]       code_n, up, dn;
  logic [TRIM_W-1:0]       therm;

  fll_osc_edge u_edge (
    .clock    (clock),
    .reset    (reset),
    .osc      (osc),
    .osc_rise (osc_rise)
  );

  // Free-running period counter; its value at an edge is the measured period.
  always_ff @(posedge clock) begin
    if (reset)         cnt <= '0;
    else if (osc_rise) cnt <= CNT_W'(1);
    else if (cnt != '1) cnt <= cnt + CNT_W'(1);
  end

  assign err     = $signed({1'b0, cnt}) - $signed({3'b000, div});
  assign err_abs = err[ERR_W-1] ? ERR_W'(-err) : ERR_W'(err);
  assign in_win  = (div != '0) && (err_abs <= ERR_W'(TOL));

  assign code_x = {1'b0, code};
  assign step   = (err_abs > ERR_W'(COARSE_TH)) ? (CODE_W+1)'(COARSE_STEP) : (CODE_W+1)'(1);
  assign sum    = code_x + step;
  assign up     = (sum > (CODE_W+1)'(TRIM_W)) ? CODE_W'(TRIM_W) : sum[CODE_W-1:0];
  assign dn     = (code_x < step) ? '0 : CODE_W'(code_x - step);

  always_comb begin
    state_n = state;
    code_n  = code;
    eval    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      code_n  = CODE_W'(TRIM_INIT);
    end else if (dco) begin
      state_n = DCO;
    end else begin
      case (state)
        IDLE:    if (osc_rise) state_n = TRACK;
        TRACK:   eval = osc_rise;
        default: state_n = IDLE;
      endcase
    end
    // Positive error means too many DCO cycles per period: DCO is fast.
    if (eval && (div != '0) && !in_win)
      code_n = err[ERR_W-1] ? dn : up;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      code  <= CODE_W'(TRIM_INIT);
    end else begin
      state <= state_n;
      code  <= code_n;
    end
  end

  for (genvar i = 0; i < TRIM_W; i++) begin : g_therm
    assign therm[i] = (CODE_W'(i) < code);
  end

  assign trim = dco ? ext_trim : therm;

`ifdef FLL_LOCK_DETECT_EN
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  logic [RUN_W-1:0] run;
  logic             lock_q;

  always_ff @(posedge clock) begin
    if (reset || !enable || dco || state != TRACK) begin
      run    <= '0;
      lock_q <= 1'b0;
    end else if (eval) begin
      if (in_win) begin
        if (run != RUN_W'(LOCK_COUNT)) run <= run + RUN_W'(1);
        lock_q <= (run >= RUN_W'(LOCK_COUNT - 1));
      end else begin
        run    <= '0;
        lock_q <= 1'b0;
      end
    end
  end

  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_digital_fll_controller.sv
// Directed bench for digital_fll_controller with an event-time reference model.
module tb_digital_fll_controller;

  localparam int TRIM_W = 26;
  localparam int DIV_W  = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic              osc = 1'b0;
  logic              dco = 1'b0;
  logic [DIV_W-1:0]  div = 5'd8;
  logic [TRIM_W-1:0] ext_trim = '0;
  logic [TRIM_W-1:0] trim;
  logic [4:0]        code;
  logic              locked;

  digital_fll_controller dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .osc      (osc),
    .div      (div),
    .dco      (dco),
    .ext_trim (ext_trim),
    .trim     (trim),
    .code     (code),
    .locked   (locked)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int per   = 0;
  int ph    = 0;
  int pend[$];

  // Reference model state: mode 0 idle, 1 tracking, 2 bypass.
  int m_code = 13;
  int m_mode = 0;
  int m_run  = 0;
  int m_prev = 0;
  bit m_lock = 1'b0;

  function automatic logic [TRIM_W-1:0] therm(input int c);
    logic [TRIM_W-1:0] t;
    for (int i = 0; i < TRIM_W; i++) t[i] = (i < c);
    return t;
  endfunction

  function automatic logic exp_locked();
`ifdef FLL_LOCK_DETECT_EN
    return m_lock;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference oscillator; a rise launched after posedge n is acted on at posedge n+3.
  always @(negedge clock) begin
    #1;
    if (per == 0) begin
      ph  = 0;
      osc = 1'b0;
    end else begin
      if (ph >= per) ph = 0;
      if (ph < per / 2 && !osc) pend.push_back(cyc + 3);
      osc = (ph < per / 2);
      ph++;
    end
  end

  // Model update and per-cycle comparison.
  always @(posedge clock) begin
    bit e;
    int meas, err, st;
    cyc++;
    e    = 1'b0;
    meas = 0;
    if (pend.size() > 0 && pend[0] == cyc) begin
      e = 1'b1;
      void'(pend.pop_front());
    end
    if (reset) begin
      m_code = 13; m_mode = 0; m_run = 0; m_lock = 1'b0;
      pend.delete();
      m_prev = cyc + 1;
    end else begin
      if (e) begin
        meas   = (cyc - m_prev > 127) ? 127 : cyc - m_prev;
        m_prev = cyc;
      end
      if (!enable) begin
        m_mode = 0; m_code = 13; m_run = 0; m_lock = 1'b0;
      end else if (dco) begin
        m_mode = 2; m_run = 0; m_lock = 1'b0;
      end else if (m_mode == 0) begin
        if (e) m_mode = 1;
        m_run = 0; m_lock = 1'b0;
      end else if (m_mode == 2) begin
        m_mode = 0; m_run = 0; m_lock = 1'b0;
      end else if (e) begin
        err = meas - int'(div);
        if (div != 0 && err >= -1 && err <= 1) begin
          m_run++;
          if (m_run >= 8) m_lock = 1'b1;
        end else begin
          m_run = 0; m_lock = 1'b0;
          if (div != 0) begin
            st = (err > 4 || err < -4) ? 4 : 1;
            if (err > 0) m_code = (m_code + st > 26) ? 26 : m_code + st;
            else         m_code = (m_code - st < 0) ? 0 : m_code - st;
          end
        end
      end
    end
    #2;
    check("cyc_code", 32'(code), 32'(m_code));
    check("cyc_trim", 32'(trim), 32'(dco ? ext_trim : therm(m_code)));
    check("cyc_locked", 32'(locked), 32'(exp_locked()));
  end

  initial begin
    int snap;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_code", 32'(code), 32'd13);
    check("rst_trim", 32'(trim), 32'h0001FFF);
    check("rst_locked", 32'(locked), 32'd0);

    // Period 12, div 8: err +4, fine steps; first edge only arms tracking.
    per = 12;
    repeat (16) @(negedge clock);
    check("fine_code14", 32'(code), 32'd14);
    check("fine_trim14", 32'(trim), 32'h0003FFF);
    repeat (14) @(negedge clock);
    check("fine_code15", 32'(code), 32'd15);
    check("model_code15", 32'(m_code), 32'd15);

    // Period 16: err +8, coarse steps up to saturation.
    per = 16;
    repeat (120) @(negedge clock);
    check("sat_code", 32'(code), 32'd26);
    check("sat_trim", 32'(trim), 32'h3FFFFFF);

    // Period 8 in-window, then one period of 11.
    per = 8;
    repeat (100) @(negedge clock);
`ifdef FLL_LOCK_DETECT_EN
    check("lock_set", 32'(locked), 32'd1);
`endif
    @(posedge osc);
    per = 11;
    @(posedge osc);
    per = 8;
    repeat (6) @(negedge clock);
    check("lock_clr", 32'(locked), 32'd0);
    check("sat_hold", 32'(code), 32'd26);

    // Period 2, div 20: coarse steps down, floor at 0.
    div = 5'd20;
    per = 2;
    repeat (60) @(negedge clock);
    check("floor_code", 32'(code), 32'd0);
    check("floor_trim", 32'(trim), 32'd0);
    check("model_floor", 32'(m_code), 32'd0);

    // Bypass mid-period.
    div = 5'd8;
    per = 12;
    repeat (30) @(negedge clock);
    repeat (5) @(negedge clock);
    dco      = 1'b1;
    ext_trim = 26'h2AAAAAA;
    #1;
    check("dco_trim", 32'(trim), 32'h2AAAAAA);
    snap = m_code;
    repeat (40) @(negedge clock);
    check("dco_hold", 32'(code), 32'(snap));
    dco = 1'b0;
    #1;
    check("dco_exit_trim", 32'(trim), 32'(therm(snap)));
    repeat (40) @(negedge clock);

    // Drive the code to 20, then a one-cycle disable.
    for (int i = 0; i < 600 && m_code != 20; i++) @(negedge clock);
    check("reach20", 32'(m_code), 32'd20);
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    check("dis_code", 32'(code), 32'd13);
    check("dis_locked", 32'(locked), 32'd0);

    // Reset together with bypass.
    per = 0;
    repeat (3) @(negedge clock);
    dco      = 1'b1;
    ext_trim = 26'h1234567;
    reset    = 1'b1;
    @(negedge clock);
    check("rst_dco_code", 32'(code), 32'd13);
    check("rst_dco_locked", 32'(locked), 32'd0);
    check("rst_dco_trim", 32'(trim), 32'h1234567);
    reset = 1'b0;
    dco   = 1'b0;
    #1;
    check("rst_dco_exit", 32'(trim), 32'h0001FFF);
    repeat (4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
